// File: rtl/de_regfile_scoreboard_pkg.sv
// rtl/de_regfile_scoreboard_pkg.sv - shared constants, WB bundle layout and CSR window helpers
package de_regfile_scoreboard_pkg;

    localparam int DBITS      = 32;
    localparam int REGNOBITS  = 5;
    localparam int REGWORDS   = 32;
    localparam int CSRNOBITS  = 12;
    localparam int CSR_WORDS  = 4;
    localparam int CSRIDXBITS = $clog2(CSR_WORDS);
    localparam int SB_BITS    = 2;

    localparam logic [CSRNOBITS-1:0] CSR_BASE = 12'h300;

    localparam int WB_FIELD_WR_REG_BITS = 1;
    localparam int WB_FIELD_WR_CSR_BITS = 1;
    localparam int WB_BUNDLE_WIDTH      = WB_FIELD_WR_REG_BITS + REGNOBITS + DBITS
                                        + CSRNOBITS + WB_FIELD_WR_CSR_BITS;

    // Field order matches the wire bundle, MSB first.
    typedef struct packed {
        logic                 wr_reg;
        logic [REGNOBITS-1:0] wregno;
        logic [DBITS-1:0]     regval;
        logic [CSRNOBITS-1:0] wcsrno;
        logic                 wr_csr;
    } wb_bundle_t;

    function automatic logic csr_in_window(input logic [CSRNOBITS-1:0] addr);
        return (addr >= CSR_BASE) && (addr < (CSR_BASE + CSRNOBITS'(CSR_WORDS)));
    endfunction

    function automatic logic [CSRIDXBITS-1:0] csr_index(input logic [CSRNOBITS-1:0] addr);
        return CSRIDXBITS'(addr - CSR_BASE);
    endfunction

endpackage

// File: rtl/de_regfile_scoreboard_if.sv
// rtl/de_regfile_scoreboard_if.sv - WB bundle, read ports and issue port between DE and the regfile
interface de_regfile_scoreboard_if;
    import de_regfile_scoreboard_pkg::*;

    logic [WB_BUNDLE_WIDTH-1:0] from_WB_to_DE;
    logic [REGNOBITS-1:0]       rs1;
    logic [REGNOBITS-1:0]       rs2;
    logic [DBITS-1:0]           rs1_val;
    logic [DBITS-1:0]           rs2_val;
    logic [CSRNOBITS-1:0]       csr_rno;
    logic [DBITS-1:0]           csr_rval;
    logic                       issue_valid;
    logic                       issue_wr_reg;
    logic [REGNOBITS-1:0]       issue_rd;
    logic                       rs1_busy;
    logic                       rs2_busy;
    logic                       rd_full;
    logic                       sb_err;

    modport master (
        output from_WB_to_DE, rs1, rs2, csr_rno, issue_valid, issue_wr_reg, issue_rd,
        input  rs1_val, rs2_val, csr_rval, rs1_busy, rs2_busy, rd_full, sb_err
    );

    modport slave (
        input  from_WB_to_DE, rs1, rs2, csr_rno, issue_valid, issue_wr_reg, issue_rd,
        output rs1_val, rs2_val, csr_rval, rs1_busy, rs2_busy, rd_full, sb_err
    );

endinterface

// File: rtl/de_regfile_scoreboard_sb_counter_bank.sv
// rtl/de_regfile_scoreboard_sb_counter_bank.sv - per-register in-flight counters with busy/full/error flags
module de_regfile_scoreboard_sb_counter_bank
    import de_regfile_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid_i,
    input  logic                 issue_wr_reg_i,
    input  logic [REGNOBITS-1:0] issue_rd_i,
    input  logic                 dec_valid_i,
    input  logic [REGNOBITS-1:0] dec_regno_i,
    input  logic [REGNOBITS-1:0] rs1_i,
    input  logic [REGNOBITS-1:0] rs2_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o,
    output logic                 rd_full_o,
    output logic                 sb_err_o
);

    localparam logic [SB_BITS-1:0] CNT_MAX = '1;
    localparam logic [SB_BITS-1:0] CNT_ONE = SB_BITS'(1);

    logic [SB_BITS-1:0] cnt_q [REGWORDS];
    logic [SB_BITS-1:0] cnt_d [REGWORDS];
    logic               sb_err_q;
    logic               sb_err_d;
    logic               inc;
    logic               dec;

    assign rd_full_o = (issue_rd_i != '0) && (cnt_q[issue_rd_i] == CNT_MAX);
    assign inc       = issue_valid_i && issue_wr_reg_i && (issue_rd_i != '0) && !rd_full_o;
    assign dec       = dec_valid_i && (dec_regno_i != '0);

    // A register whose only outstanding write lands this cycle is served by the WB bypass.
    assign rs1_busy_o = (rs1_i != '0) && (cnt_q[rs1_i] != '0)
                     && !((cnt_q[rs1_i] == CNT_ONE) && dec && (dec_regno_i == rs1_i));
    assign rs2_busy_o = (rs2_i != '0) && (cnt_q[rs2_i] != '0)
                     && !((cnt_q[rs2_i] == CNT_ONE) && dec && (dec_regno_i == rs2_i));

    assign sb_err_o = sb_err_q;

    always_comb begin
        sb_err_d = sb_err_q
                || (dec && (cnt_q[dec_regno_i] == '0))
                || (issue_valid_i && issue_wr_reg_i && rd_full_o);
        cnt_d[0] = '0;
        for (int r = 1; r < REGWORDS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc && (issue_rd_i == REGNOBITS'(r))
                    && !(dec && (dec_regno_i == REGNOBITS'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && (dec_regno_i == REGNOBITS'(r))
                    && !(inc && (issue_rd_i == REGNOBITS'(r)))
                    && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGWORDS; r++) begin
                cnt_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: rtl/de_regfile_scoreboard.sv
// rtl/de_regfile_scoreboard.sv - DE-side integer/CSR register file with WB bypass and hazard scoreboard
module de_regfile_scoreboard
    import de_regfile_scoreboard_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    de_regfile_scoreboard_if.slave bus
);

    wb_bundle_t       wb;
    logic [DBITS-1:0] rf_q  [REGWORDS];
    logic [DBITS-1:0] rf_d  [REGWORDS];
    logic [DBITS-1:0] csr_q [CSR_WORDS];
    logic [DBITS-1:0] csr_d [CSR_WORDS];
    logic             wb_reg_wr;

    assign wb        = wb_bundle_t'(bus.from_WB_to_DE);
    assign wb_reg_wr = wb.wr_reg && (wb.wregno != '0);

    always_comb begin
        rf_d  = rf_q;
        csr_d = csr_q;
        if (wb_reg_wr) begin
            rf_d[wb.wregno] = wb.regval;
        end
        if (wb.wr_csr && csr_in_window(wb.wcsrno)) begin
            csr_d[csr_index(wb.wcsrno)] = wb.regval;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGWORDS; r++) begin
                rf_q[r] <= '0;
            end
            for (int c = 0; c < CSR_WORDS; c++) begin
                csr_q[c] <= '0;
            end
        end else begin
            rf_q  <= rf_d;
            csr_q <= csr_d;
        end
    end

    // Same-cycle WB data wins over the array so DE never reads a value one cycle stale.
    always_comb begin
        bus.rs1_val = rf_q[bus.rs1];
        if (bus.rs1 == '0) begin
            bus.rs1_val = '0;
        end else if (wb.wr_reg && (wb.wregno == bus.rs1)) begin
            bus.rs1_val = wb.regval;
        end

        bus.rs2_val = rf_q[bus.rs2];
        if (bus.rs2 == '0) begin
            bus.rs2_val = '0;
        end else if (wb.wr_reg && (wb.wregno == bus.rs2)) begin
            bus.rs2_val = wb.regval;
        end

        bus.csr_rval = '0;
        if (csr_in_window(bus.csr_rno)) begin
            if (wb.wr_csr && (wb.wcsrno == bus.csr_rno)) begin
                bus.csr_rval = wb.regval;
            end else begin
                bus.csr_rval = csr_q[csr_index(bus.csr_rno)];
            end
        end
    end

    de_regfile_scoreboard_sb_counter_bank u_sb_counter_bank (
        .clk            (clk),
        .reset          (reset),
        .issue_valid_i  (bus.issue_valid),
        .issue_wr_reg_i (bus.issue_wr_reg),
        .issue_rd_i     (bus.issue_rd),
        .dec_valid_i    (wb.wr_reg),
        .dec_regno_i    (wb.wregno),
        .rs1_i          (bus.rs1),
        .rs2_i          (bus.rs2),
        .rs1_busy_o     (bus.rs1_busy),
        .rs2_busy_o     (bus.rs2_busy),
        .rd_full_o      (bus.rd_full),
        .sb_err_o       (bus.sb_err)
    );

endmodule
